// File: rtl/sr_shifter.sv
// sr_shifter: parallel-load serial shifter driving a 74HC595-style chain, with storage-clock pulse
module sr_shifter #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_load,
    input  logic             i_latch,
    output logic             o_busy,
    output logic             o_sdata,
    output logic             o_sclk,
    output logic             o_rclk,
    output logic             o_overrun
);
    localparam int BW = $clog2(WIDTH) + 1;
    localparam int DW = $clog2(DIV) + 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] nxt;
    logic [BW-1:0]    bcnt;
    logic [DW-1:0]    dcnt;
    logic [DW-1:0]    rcnt;

    // word as it looks after moving the just-sent bit out
    always_comb nxt = MSB_FIRST ? sreg << 1 : sreg >> 1;

    // shift FSM: LOW sets up data, HIGH presents the rising sclk edge; each lasts DIV cycles
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            sreg      <= '0;
            bcnt      <= '0;
            dcnt      <= '0;
            o_busy    <= 1'b0;
            o_sclk    <= 1'b0;
            o_sdata   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (i_load && state != IDLE) o_overrun <= 1'b1;
            case (state)
                IDLE: if (i_load) begin
                    state   <= LOW;
                    sreg    <= i_data;
                    bcnt    <= '0;
                    dcnt    <= '0;
                    o_busy  <= 1'b1;
                    o_sdata <= MSB_FIRST ? i_data[WIDTH-1] : i_data[0];
                end
                LOW: if (dcnt == LAST_DIV) begin
                    state  <= HIGH;
                    dcnt   <= '0;
                    o_sclk <= 1'b1;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                HIGH: if (dcnt == LAST_DIV) begin
                    dcnt   <= '0;
                    o_sclk <= 1'b0;
                    if (bcnt == LAST_BIT) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_sdata <= 1'b0;
                    end else begin
                        state   <= LOW;
                        sreg    <= nxt;
                        bcnt    <= bcnt + 1'b1;
                        o_sdata <= MSB_FIRST ? nxt[WIDTH-1] : nxt[0];
                    end
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // storage-clock pulse of DIV cycles; a latch arriving mid-pulse is dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rclk <= 1'b0;
            rcnt   <= '0;
        end else if (o_rclk) begin
            o_rclk <= rcnt != LAST_DIV;
            rcnt   <= rcnt + 1'b1;
        end else if (i_latch) begin
            o_rclk <= 1'b1;
            rcnt   <= '0;
        end
    end
endmodule
